// File: rtl/mem_io_pkg.sv
// Shared constants, stop-sequencer state type and a byte-select helper
// for the CPU memory/IO responder.
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam logic [31:0] IO_PORT_ADDR = 32'h0003_0000;
    localparam logic [31:0] IO_CLK_ADDR  = 32'h0003_0004;

    typedef enum logic [1:0] {
        IDLE,
        PUSH0,
        DRAIN,
        DONE
    } stop_state_t;

    function automatic logic [7:0] dword_byte(input logic [31:0] word, input logic [1:0] sel);
        return word[8*sel +: 8];
    endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO with occupancy count; a push into a full FIFO is still accepted
// when a pop happens in the same cycle. Head reads as 0x00 while empty.
module io_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_in,
    input  logic [7:0]               push_data_in,
    input  logic                     pop_in,
    output logic [7:0]               pop_data_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop_in && (count_q != '0);
        push_ok  = push_in && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty gate on the head keeps X off the outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in && push_ok) begin
            mem_q[wr_ptr_q] <= push_data_in;
        end
    end

    assign empty_out    = (count_q == '0);
    assign full_out     = (count_q == CW'(DEPTH));
    assign count_out    = count_q;
    assign pop_data_out = empty_out ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: RAM, tx/rx byte FIFOs, cycle counter and program-stop sequencer.
// Define ADDR_CHECK_EN to add the sticky addr_err_out port and suppress bad-address accesses.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_in,
    input  logic [31:0] cpu_a_in,
    input  logic        cpu_wr_in,
    input  logic [7:0]  cpu_dout_in,
    output logic [7:0]  cpu_din_out,
    output logic        io_buffer_full_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic        program_done_out,
    output logic        tx_overflow_out
`ifdef ADDR_CHECK_EN
    ,
    output logic        addr_err_out
`endif
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]        mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] ram_idx;

    logic [7:0]  cpu_din_q, cpu_din_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] snapshot_q, snapshot_d;
    logic        io_full_q, io_full_d;
    logic        tx_overflow_q, tx_overflow_d;
    logic        done_q, done_d;
    stop_state_t state_q, state_d;

    logic             is_io, hit_port, hit_clk, addr_bad;
    logic             rd_access, rd_ok, wr_ok, ram_we;
    logic             cpu_tx_req, stop_req, fsm_push;
    logic             tx_push, tx_push_ok, tx_pop, tx_full, tx_empty;
    logic [7:0]       tx_push_data, tx_head;
    logic [TX_CW-1:0] tx_count, tx_cnt_next;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_head;
    logic [RX_CW-1:0] unused_rx_count;

`ifdef ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;
    assign addr_bad     = en_in && ((cpu_a_in[31:18] != '0) || (cpu_a_in[17:16] == 2'b10));
    assign addr_err_d   = addr_err_q || addr_bad;
    assign addr_err_out = addr_err_q;
`else
    logic unused_addr_bits;
    assign addr_bad         = 1'b0;
    assign unused_addr_bits = ^cpu_a_in[31:18];
`endif

    assign ram_idx   = cpu_a_in[ADDR_W-1:0];
    assign is_io     = (cpu_a_in[17:16] == IO_SEL);
    assign hit_port  = is_io && (cpu_a_in[17:0] == IO_PORT_ADDR[17:0]);
    assign hit_clk   = is_io && (cpu_a_in[17:2] == IO_CLK_ADDR[17:2]);
    assign rd_access = en_in && !cpu_wr_in;
    assign rd_ok     = rd_access && !addr_bad;
    assign wr_ok     = en_in && cpu_wr_in && !addr_bad;
    assign ram_we    = wr_ok && !is_io;

    // The CPU only reaches the IO ports while the stop sequencer is idle.
    assign cpu_tx_req   = wr_ok && hit_port && (state_q == IDLE) && (cpu_dout_in != 8'h00);
    assign stop_req     = wr_ok && hit_clk && (state_q == IDLE);
    assign fsm_push     = (state_q == PUSH0) && !tx_full;
    assign tx_push      = cpu_tx_req || fsm_push;
    assign tx_push_data = fsm_push ? 8'h00 : cpu_dout_in;
    assign tx_pop       = !tx_empty && tx_ready_in;
    assign tx_push_ok   = tx_push && (!tx_full || tx_pop);
    assign tx_cnt_next  = tx_count + TX_CW'(tx_push_ok) - TX_CW'(tx_pop);
    assign rx_push      = rx_valid_in && !rx_full;
    assign rx_pop       = rd_ok && hit_port && !rx_empty;

    io_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (tx_push),
        .push_data_in (tx_push_data),
        .pop_in       (tx_pop),
        .pop_data_out (tx_head),
        .full_out     (tx_full),
        .empty_out    (tx_empty),
        .count_out    (tx_count)
    );

    io_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (rx_push),
        .push_data_in (rx_data_in),
        .pop_in       (rx_pop),
        .pop_data_out (rx_head),
        .full_out     (rx_full),
        .empty_out    (rx_empty),
        .count_out    (unused_rx_count)
    );

    always_comb begin
        cpu_din_d  = cpu_din_q;
        snapshot_d = snapshot_q;
        counter_d  = en_in ? counter_q + 32'd1 : counter_q;
        if (rd_access) begin
            if (addr_bad) begin
                cpu_din_d = 8'h00;
            end else if (!is_io) begin
                cpu_din_d = mem_q[ram_idx];
            end else if (hit_port) begin
                cpu_din_d = rx_head;
            end else if (hit_clk) begin
                // Byte 0 latches the whole counter so bytes 1..3 read back coherently.
                if (cpu_a_in[1:0] == 2'd0) begin
                    snapshot_d = counter_q;
                    cpu_din_d  = counter_q[7:0];
                end else begin
                    cpu_din_d = dword_byte(snapshot_q, cpu_a_in[1:0]);
                end
            end else begin
                cpu_din_d = 8'h00;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (stop_req) state_d = PUSH0;
            PUSH0:   if (!tx_full) state_d = DRAIN;
            DRAIN:   if (tx_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        done_d        = (state_d == DONE);
        tx_overflow_d = tx_overflow_q || (cpu_tx_req && tx_full && !tx_pop);
        // Two spare entries absorb writes the CPU issues before it sees the flag.
        io_full_d     = (TX_CW'(TX_DEPTH) - tx_cnt_next) <= TX_CW'(2);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cpu_din_q     <= 8'h00;
            counter_q     <= 32'd0;
            snapshot_q    <= 32'd0;
            io_full_q     <= 1'b0;
            tx_overflow_q <= 1'b0;
            done_q        <= 1'b0;
            state_q       <= IDLE;
`ifdef ADDR_CHECK_EN
            addr_err_q    <= 1'b0;
`endif
        end else begin
            cpu_din_q     <= cpu_din_d;
            counter_q     <= counter_d;
            snapshot_q    <= snapshot_d;
            io_full_q     <= io_full_d;
            tx_overflow_q <= tx_overflow_d;
            done_q        <= done_d;
            state_q       <= state_d;
`ifdef ADDR_CHECK_EN
            addr_err_q    <= addr_err_d;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && ram_we) begin
            mem_q[ram_idx] <= cpu_dout_in;
        end
    end

    assign cpu_din_out        = cpu_din_q;
    assign io_buffer_full_out = io_full_q;
    assign tx_data_out        = tx_head;
    assign tx_valid_out       = !tx_empty;
    assign rx_ready_out       = !rx_full;
    assign program_done_out   = done_q;
    assign tx_overflow_out    = tx_overflow_q;

endmodule
